// File: rtl/shift_add_multiplier_16_pkg.sv
// Shared constants and state encoding for the shift-add multiplier.
package mult_pkg;
    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = 5;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/shift_add_multiplier_16_if.sv
// Start/done handshake and operand/result bus of the multiplier.
interface shift_add_multiplier_16_if;
    import mult_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier_16_adder.sv
// 16-bit ripple-carry adder shared with the ALU; c14 is the carry into the MSB.
module ripple_adder_16
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c14
);
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        c14   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            if (i == WIDTH - 1) c14 = carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/shift_add_multiplier_16.sv
// Multi-cycle unsigned 16x16->32 multiplier: one conditional add plus right shift per cycle.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on accept
//   S_RUN  | 16 add/shift iterations, busy=1
//   S_DONE | one-cycle done pulse, product valid
module shift_add_multiplier_16
    import mult_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    shift_add_multiplier_16_if.slave bus
);
    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product_q;
    logic [CNT_W-1:0]     count;
    logic                 cout;
    logic                 c14_unused;

    assign addend = mcand & {WIDTH{acc[0]}};

    ripple_adder_16 u_adder (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout),
        .c14  (c14_unused)
    );

    // Carry lands in bit 31 so the full 32-bit product is preserved.
    assign acc_next = {cout, sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mcand     <= '0;
            acc       <= '0;
            count     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        acc   <= {{WIDTH{1'b0}}, bus.b};
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITER - 1)) begin
                        product_q <= acc_next;
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == S_RUN);
    assign bus.done    = (state == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier_16.sv
// Randomized self-checking bench for shift_add_multiplier_16 against an arithmetic model.
module tb_shift_add_multiplier_16;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    shift_add_multiplier_16_if m ();

    shift_add_multiplier_16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; glitch_at >= 0 fires an extra start with junk operands mid-run.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int glitch_at);
        logic [31:0] exp;
        logic [31:0] prev;
        int          n;
        int          busy_n;
        logic        hold_bad;
        exp = 32'(av) * 32'(bv);
        @(posedge clk); #1;
        m.start = 1'b1; m.a = av; m.b = bv;
        @(posedge clk); #1;
        m.start = 1'b0; m.a = 16'($urandom); m.b = 16'($urandom);
        prev = m.product; n = 0; busy_n = 0; hold_bad = 1'b0;
        while (!m.done && n < 40) begin
            if (m.busy) busy_n++;
            if (m.product !== prev) hold_bad = 1'b1;
            if (n == glitch_at) begin
                m.start = 1'b1; m.a = 16'($urandom); m.b = 16'($urandom);
            end else begin
                m.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        m.start = 1'b0;
        chk("latency", 32'(n), 32'd16);
        chk("busy_cycles", 32'(busy_n), 32'd16);
        chk("done_seen", {31'b0, m.done}, 32'd1);
        chk("busy_in_done", {31'b0, m.busy}, 32'd0);
        chk("product", m.product, exp);
        chk("no_intermediate", {31'b0, hold_bad}, 32'd0);
        @(posedge clk); #1;
        chk("done_single", {31'b0, m.done}, 32'd0);
        chk("product_hold", m.product, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last;
        int first;
        int pulses;
        int n;
        int done_seen;
        checks = 0; failures = 0;
        reset = 1'b1; m.start = 1'b0; m.a = '0; m.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, m.busy}, 32'd0);
        chk("rst_done", {31'b0, m.done}, 32'd0);
        chk("rst_product", m.product, 32'd0);
        reset = 1'b0;

        do_op(16'd3, 16'd5, -1);
        do_op(16'hFFFF, 16'hFFFF, -1);
        do_op(16'h0000, 16'h1234, -1);
        do_op(16'h1234, 16'h0000, -1);
        do_op(16'd7, 16'd9, 4);
        do_op(16'h8001, 16'hFFFF, 15);

        // Reset in the middle of a run aborts it and clears the result.
        @(posedge clk); #1;
        m.start = 1'b1; m.a = 16'd100; m.b = 16'd200;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, m.busy}, 32'd0);
        chk("abort_done", {31'b0, m.done}, 32'd0);
        chk("abort_product", m.product, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (m.done || m.busy) done_seen++;
        end
        chk("abort_quiet", 32'(done_seen), 32'd0);
        do_op(16'd2, 16'd3, -1);

        // Start held high: one done every 18 cycles.
        @(posedge clk); #1;
        m.a = 16'h00FF; m.b = 16'h0101; m.start = 1'b1;
        last = -1; first = -1; pulses = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (m.done) begin
                pulses++;
                chk("held_product", m.product, 32'h0000FFFF);
                if (last >= 0) chk("held_period", 32'(k - last), 32'd18);
                else first = k;
                last = k;
            end
        end
        chk("held_first", 32'(first), 32'd17);
        chk("held_pulses", 32'(pulses), 32'd4);
        m.start = 1'b0;
        n = 0;
        while (!m.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_drain", {31'b0, m.done}, 32'd1);
        @(posedge clk); #1;

        for (int r = 0; r < 24; r++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            int          g;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (r % 6 == 0) ra = 16'hFFFF;
            if (r % 7 == 0) rb = 16'hFFFF;
            g = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
            do_op(ra, rb, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
